reaction_ctrl: RTL and testbench

//  Trial controller downstream of RandomGen. Start latches RandomGen's 13-bit RandomValue as a random foreperiod.

---
 rtl/reaction_pkg.sv | 31 +++
 rtl/ms_prescaler.sv | 29 ++
 rtl/reaction_ctrl.sv | 150 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared widths, state encoding and the foreperiod helper for the reaction-time trial controller.
package reaction_pkg;

    localparam int MS_W   = 14;
    localparam int RAND_W = 13;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_EARLY   = 3'd5;
    localparam logic [2:0] S_TIMEOUT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_ARM     = S_ARM,
        ST_WAIT    = S_WAIT,
        ST_RUN     = S_RUN,
        ST_DONE    = S_DONE,
        ST_EARLY   = S_EARLY,
        ST_TIMEOUT = S_TIMEOUT
    } state_t;

    // Foreperiod in ms; 14 bits hold the worst case 1000 + 8191 without wrapping.
    function automatic logic [MS_W-1:0] wait_target(input logic [RAND_W-1:0] rnd,
                                                    input int              min_wait_ms);
        return MS_W'(min_wait_ms) + MS_W'(rnd);
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond tick generator: counts 0..TICKS_PER_MS-1 and pulses tick on the wrap cycle.
module ms_prescaler #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == LAST);

    // A clear lands on the state-entry edge, so the first tick is a full period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial controller: random foreperiod, stimulus LED, ms reaction measurement,
// false-start and timeout detection with a latched result for the display stage.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_WAIT_MS  = 1000,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              react,
    input  logic [RAND_W-1:0] random_value,
    output logic              led_on,
    output logic [MS_W-1:0]   react_time,
    output logic              result_valid,
    output logic              early_flag,
    output logic              timeout_flag,
    output logic              busy
);

    localparam logic [MS_W-1:0] MAX_MS = MS_W'(MAX_REACT_MS);

    state_t          state_reg;
    logic            start_prev_reg;
    logic            react_prev_reg;
    logic [MS_W-1:0] ms_cnt_reg;
    logic [MS_W-1:0] wait_target_reg;
    logic [MS_W-1:0] react_time_reg;
    logic            led_on_reg;
    logic            result_valid_reg;
    logic            early_flag_reg;
    logic            timeout_flag_reg;
    logic            busy_reg;

    logic start_pulse;
    logic react_pulse;
    logic wait_done;
    logic run_expired;
    logic presc_clr;
    logic tick;

    assign start_pulse = start & ~start_prev_reg;
    assign react_pulse = react & ~react_prev_reg;
    assign wait_done   = (ms_cnt_reg == wait_target_reg);
    assign run_expired = (ms_cnt_reg == MAX_MS);

    // Mirrors every transition of the FSM below so the prescaler restarts on each state entry.
    always_comb begin
        presc_clr = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: presc_clr = start_pulse;
            ST_ARM:                                 presc_clr = 1'b1;
            ST_WAIT:                                presc_clr = react_pulse | wait_done;
            ST_RUN:                                 presc_clr = react_pulse | run_expired;
            default:                                presc_clr = 1'b1;
        endcase
    end

    ms_prescaler #(
        .TICKS_PER_MS(TICKS_PER_MS)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            start_prev_reg   <= 1'b0;
            react_prev_reg   <= 1'b0;
            ms_cnt_reg       <= '0;
            wait_target_reg  <= '0;
            react_time_reg   <= '0;
            led_on_reg       <= 1'b0;
            result_valid_reg <= 1'b0;
            early_flag_reg   <= 1'b0;
            timeout_flag_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            start_prev_reg <= start;
            react_prev_reg <= react;
            case (state_reg)
                // Results are cleared on the way into ARM so a new trial never shows a stale result.
                ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: begin
                    if (start_pulse) begin
                        state_reg        <= ST_ARM;
                        busy_reg         <= 1'b1;
                        led_on_reg       <= 1'b0;
                        react_time_reg   <= '0;
                        result_valid_reg <= 1'b0;
                        early_flag_reg   <= 1'b0;
                        timeout_flag_reg <= 1'b0;
                    end
                end
                ST_ARM: begin
                    wait_target_reg <= wait_target(random_value, MIN_WAIT_MS);
                    ms_cnt_reg      <= '0;
                    state_reg       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (react_pulse) begin
                        state_reg      <= ST_EARLY;
                        early_flag_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                    end else if (wait_done) begin
                        state_reg  <= ST_RUN;
                        led_on_reg <= 1'b1;
                        ms_cnt_reg <= '0;
                    end else if (tick) begin
                        ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
                    end
                end
                ST_RUN: begin
                    if (react_pulse) begin
                        state_reg        <= ST_DONE;
                        react_time_reg   <= ms_cnt_reg;
                        result_valid_reg <= 1'b1;
                        led_on_reg       <= 1'b0;
                        busy_reg         <= 1'b0;
                    end else if (run_expired) begin
                        state_reg        <= ST_TIMEOUT;
                        react_time_reg   <= MAX_MS;
                        timeout_flag_reg <= 1'b1;
                        led_on_reg       <= 1'b0;
                        busy_reg         <= 1'b0;
                    end else if (tick) begin
                        ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    led_on_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign led_on       = led_on_reg;
    assign react_time   = react_time_reg;
    assign result_valid = result_valid_reg;
    assign early_flag   = early_flag_reg;
    assign timeout_flag = timeout_flag_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: trial-level timing model predicts every output each cycle of a trial.
module tb_reaction_ctrl;

    localparam int T    = 4;
    localparam int MINW = 10;
    localparam int MAXR = 50;

    localparam int O_DONE  = 0;
    localparam int O_EARLY = 1;
    localparam int O_TO    = 2;

    typedef struct {
        int outcome;
        int end_rel;
        int led_rel;
        int rtime;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [12:0] random_value = '0;
    logic        led_on;
    logic [13:0] react_time;
    logic        result_valid;
    logic        early_flag;
    logic        timeout_flag;
    logic        busy;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    string cur_trial = "reset";

    reaction_ctrl #(
        .TICKS_PER_MS (T),
        .MIN_WAIT_MS  (MINW),
        .MAX_REACT_MS (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .react        (react),
        .random_value (random_value),
        .led_on       (led_on),
        .react_time   (react_time),
        .result_valid (result_valid),
        .early_flag   (early_flag),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s cyc=%0d got=%0d expected=%0d", cur_trial, tag, cyc, got, exp);
        end
    endtask

    // Trial outcome from event times, measured in cycles relative to the ARM cycle.
    // WAIT spans target*T+1 cycles, RUN begins right after, and ms = elapsed RUN cycles / T.
    function automatic pred_t predict(input int r, input int rel_p);
        pred_t p;
        int    w;
        int    run_start;
        w         = (MINW + r) * T;
        run_start = w + 2;
        p.led_rel = run_start;
        if (rel_p >= 0 && rel_p <= w + 1) begin
            p.outcome = O_EARLY;
            p.end_rel = rel_p + 1;
            p.rtime   = 0;
        end else if (rel_p >= 0 && (rel_p - run_start) <= MAXR * T) begin
            p.outcome = O_DONE;
            p.end_rel = rel_p + 1;
            p.rtime   = (rel_p - run_start) / T;
        end else begin
            p.outcome = O_TO;
            p.end_rel = run_start + MAXR * T + 1;
            p.rtime   = MAXR;
        end
        return p;
    endfunction

    task automatic check_idle_outputs();
        check("led_on", led_on, 0);
        check("busy", busy, 0);
        check("result_valid", result_valid, 0);
        check("early_flag", early_flag, 0);
        check("timeout_flag", timeout_flag, 0);
        check("react_time", react_time, 0);
    endtask

    // pre: 0 = react low before start, 1 = react rises with start, 2 = react already held high.
    task automatic run_trial(input string name, input int r, input int rel_p,
                             input int pre, input bit noise);
        pred_t p;
        int    a;
        int    n;
        int    rel_release;
        bit    term;
        cur_trial   = name;
        p           = predict(r, rel_p);
        rel_release = (rel_p >= 0) ? rel_p + $urandom_range(1, 5) : -1;
        @(negedge clk);
        start = 1'b0;
        react = (pre == 2);
        @(negedge clk);
        start        = 1'b1;
        random_value = 13'(r);
        if (pre == 1) react = 1'b1;
        a = cyc + 1;
        forever begin
            @(negedge clk);
            n = cyc - a;
            if (n > p.end_rel + 3) break;
            term = (n >= p.end_rel);
            check("busy", busy, {31'd0, !term});
            check("led_on", led_on,
                  {31'd0, (p.outcome != O_EARLY) && (n >= p.led_rel) && !term});
            check("result_valid", result_valid, {31'd0, term && p.outcome == O_DONE});
            check("early_flag", early_flag, {31'd0, term && p.outcome == O_EARLY});
            check("timeout_flag", timeout_flag, {31'd0, term && p.outcome == O_TO});
            check("react_time", react_time, term ? p.rtime : 0);
            start        = (noise && n < p.end_rel - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            random_value = (n == 0) ? 13'(r) : 13'($urandom);
            if (n == 0 && pre != 0) react = 1'b0;
            if (n == rel_p) react = 1'b1;
            if (n == rel_release) react = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic reset_mid_run();
        bit seen;
        cur_trial = "reset_mid_run";
        seen      = 1'b0;
        @(negedge clk);
        start = 1'b0;
        react = 1'b0;
        @(negedge clk);
        start        = 1'b1;
        random_value = 13'd2;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen  = led_on;
        end
        check("led_before_reset", {31'd0, seen}, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs();
        @(negedge clk);
        check_idle_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_after_release", busy, 0);
    endtask

    initial begin
        pred_t  p;
        int     r;
        int     w;
        int     cat;
        int     rel;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs();
        rst_n = 1'b1;

        cur_trial = "idle_react";
        react = 1'b1;
        repeat (3) @(negedge clk);
        react = 1'b0;
        repeat (2) @(negedge clk);
        check("busy", busy, 0);
        check("early_flag", early_flag, 0);

        run_trial("normal_r5_7ms", 5, (MINW + 5) * T + 2 + 7 * T, 0, 1'b0);
        run_trial("early_3ms", 5, 1 + 3 * T, 0, 1'b0);
        run_trial("timeout", 5, -1, 0, 1'b0);
        run_trial("rand_zero", 0, -1, 0, 1'b0);
        run_trial("react_held_before_start", 3, (MINW + 3) * T + 2 + 4 * T + 1, 2, 1'b0);
        run_trial("start_react_together", 2, (MINW + 2) * T + 2 + 9, 1, 1'b0);
        run_trial("react_on_expiry", 4, (MINW + 4) * T + 1, 0, 1'b0);
        run_trial("start_during_run", 6, (MINW + 6) * T + 2 + 20 * T, 0, 1'b1);
        run_trial("react_at_max", 1, (MINW + 1) * T + 2 + MAXR * T, 0, 1'b0);
        run_trial("rand_max_8191", 8191, (MINW + 8191) * T + 2 + 5 * T + 1, 0, 1'b0);

        reset_mid_run();
        run_trial("after_reset", 7, (MINW + 7) * T + 2 + 11 * T + 2, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            r   = $urandom_range(0, 20);
            w   = (MINW + r) * T;
            cat = $urandom_range(0, 3);
            if (cat == 0)      rel = $urandom_range(2, w + 1);
            else if (cat == 3) rel = -1;
            else               rel = w + 2 + $urandom_range(0, MAXR * T);
            p = predict(r, rel);
            run_trial($sformatf("rand%0d_o%0d", t, p.outcome), r, rel,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
